instr_decode_stage: RTL

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage_pkg.sv | 93 +++++++++
 rtl/instr_decode_stage_field_decode.sv | 71 +++++++
 rtl/instr_decode_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Shared CPU definitions for the decode stage: opcode and format types,
// the opcode-to-format map, and the decoded-entry record held in the buffer.
package instr_decode_stage_pkg;

    localparam int         INSTR_W  = 16;
    localparam int         REG_W    = 3;
    localparam logic [2:0] ZERO_REG = 3'd7;

    // Raw 4-bit opcode; codes 13..15 are reserved and decode as illegal.
    typedef logic [3:0] instrOpcode;

    localparam instrOpcode OP_ADD  = 4'h0;
    localparam instrOpcode OP_SUB  = 4'h1;
    localparam instrOpcode OP_AND  = 4'h2;
    localparam instrOpcode OP_ORR  = 4'h3;
    localparam instrOpcode OP_ADDI = 4'h4;
    localparam instrOpcode OP_SUBI = 4'h5;
    localparam instrOpcode OP_ANDI = 4'h6;
    localparam instrOpcode OP_ORRI = 4'h7;
    localparam instrOpcode OP_LDUR = 4'h8;
    localparam instrOpcode OP_STUR = 4'h9;
    localparam instrOpcode OP_CBZ  = 4'hA;
    localparam instrOpcode OP_CBNZ = 4'hB;
    localparam instrOpcode OP_B    = 4'hC;

    // FMT_R is encoded as zero so a cleared entry reads as format R.
    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_CB = 3'd3,
        FMT_B  = 3'd4
    } instrFormat;

    typedef struct packed {
        logic       mapped;
        instrFormat fmt;
    } fmt_map_t;

    // One fully decoded instruction, as stored in each buffer entry.
    typedef struct packed {
        instrOpcode          op;
        instrFormat          fmt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [INSTR_W-1:0]  imm;
        logic [INSTR_W-1:0]  pc;
        logic [INSTR_W-1:0]  target;
        logic                we;
        logic                illegal;
    } decoded_t;

    // Buffer occupancy; EMPTY is zero so reset and flush share an encoding.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    // Opcode-to-format map; unmapped opcodes report FMT_R with mapped=0.
    function automatic fmt_map_t op_to_fmt(input instrOpcode op);
        fmt_map_t m;
        m.mapped = 1'b1;
        m.fmt    = FMT_R;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR:     m.fmt = FMT_R;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: m.fmt = FMT_I;
            OP_LDUR, OP_STUR:                   m.fmt = FMT_D;
            OP_CBZ, OP_CBNZ:                    m.fmt = FMT_CB;
            OP_B:                               m.fmt = FMT_B;
            default: begin
                m.mapped = 1'b0;
                m.fmt    = FMT_R;
            end
        endcase
        return m;
    endfunction

    // Load-class D instructions are the only D format that writes a register.
    function automatic logic is_load(input instrOpcode op);
        return (op == OP_LDUR);
    endfunction

    // Branch target: pc plus the halfword offset, wrapping at 16 bits.
    function automatic logic [INSTR_W-1:0] branch_target(
        input logic [INSTR_W-1:0] pc,
        input logic [INSTR_W-1:0] imm
    );
        return pc + {imm[INSTR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/instr_decode_stage_field_decode.sv
// Purely combinational field decoder: raw instruction + pc -> decoded entry.
module instr_field_decode
    import instr_decode_stage_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic [INSTR_W-1:0] pc,
    output decoded_t           dec
);

    instrOpcode op_s;
    fmt_map_t   fmt_map_s;
    logic       r_pad_ok_s;

    assign op_s       = instr[15:12];
    assign fmt_map_s  = op_to_fmt(op_s);
    assign r_pad_ok_s = (instr[11:9] == 3'b000);

    // Split fields by format, sign-extend the immediate and derive write enable.
    always_comb begin
        dec         = '0;
        dec.op      = op_s;
        dec.pc      = pc;
        dec.fmt     = fmt_map_s.fmt;
        if (!fmt_map_s.mapped) begin
            // Reserved opcode: no fields are trusted, nothing is written.
            dec.fmt     = FMT_R;
            dec.illegal = 1'b1;
            dec.we      = 1'b0;
        end else begin
            case (fmt_map_s.fmt)
                FMT_R: begin
                    dec.rd      = instr[8:6];
                    dec.rs2     = instr[5:3];
                    dec.rs1     = instr[2:0];
                    dec.illegal = !r_pad_ok_s;
                    dec.we      = r_pad_ok_s && (instr[8:6] != ZERO_REG);
                end
                FMT_I: begin
                    dec.imm     = {{10{instr[11]}}, instr[11:6]};
                    dec.rd      = instr[5:3];
                    dec.rs1     = instr[2:0];
                    dec.we      = (instr[5:3] != ZERO_REG);
                end
                FMT_D: begin
                    // rt lands in rd, rn in rs1; only loads write rt back.
                    dec.imm     = {{10{instr[11]}}, instr[11:6]};
                    dec.rd      = instr[5:3];
                    dec.rs1     = instr[2:0];
                    dec.we      = is_load(op_s) && (instr[5:3] != ZERO_REG);
                end
                FMT_CB: begin
                    dec.imm     = {{7{instr[11]}}, instr[11:3]};
                    dec.rs1     = instr[2:0];
                    dec.target  = branch_target(pc, {{7{instr[11]}}, instr[11:3]});
                    dec.we      = 1'b0;
                end
                FMT_B: begin
                    dec.imm     = {{4{instr[11]}}, instr[11:0]};
                    dec.target  = branch_target(pc, {{4{instr[11]}}, instr[11:0]});
                    dec.we      = 1'b0;
                end
                default: begin
                    dec.fmt     = FMT_R;
                    dec.illegal = 1'b1;
                    dec.we      = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: decodes at the input, then holds up to two decoded entries
// in a skid buffer (head drives out_*, skid catches the one in flight).
module instr_decode_stage
    import instr_decode_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [INSTR_W-1:0]  in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output instrOpcode          out_op,
    output instrFormat          out_fmt,
    output logic [REG_W-1:0]    out_rd,
    output logic [REG_W-1:0]    out_rs1,
    output logic [REG_W-1:0]    out_rs2,
    output logic [INSTR_W-1:0]  out_imm,
    output logic [INSTR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0]  out_target,
    output logic                out_we,
    output logic                out_illegal
);

    decoded_t   dec_s;
    logic       accept_s;
    logic       drain_s;

    occ_state_t state_q, state_d;
    decoded_t   head_q, head_d;
    decoded_t   skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;

    instr_field_decode u_field_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec_s)
    );

    assign accept_s = in_valid && in_ready_q;
    assign drain_s  = out_valid_q && out_ready;

    // Occupancy next-state and entry movement; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        head_d  = dec_s;
                        state_d = OCC_ONE;
                    end else begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (accept_s && drain_s) begin
                        head_d  = dec_s;
                        state_d = OCC_ONE;
                    end else if (accept_s) begin
                        skid_d  = dec_s;
                        state_d = OCC_FULL;
                    end else if (drain_s) begin
                        state_d = OCC_EMPTY;
                    end else begin
                        state_d = OCC_ONE;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain_s) begin
                        head_d  = skid_q;
                        state_d = OCC_ONE;
                    end else begin
                        state_d = OCC_FULL;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != OCC_EMPTY);
        in_ready_d  = (state_d != OCC_FULL);
    end

    // State and entry registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= OCC_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_op      = head_q.op;
    assign out_fmt     = head_q.fmt;
    assign out_rd      = head_q.rd;
    assign out_rs1     = head_q.rs1;
    assign out_rs2     = head_q.rs2;
    assign out_imm     = head_q.imm;
    assign out_pc      = head_q.pc;
    assign out_target  = head_q.target;
    assign out_we      = head_q.we;
    assign out_illegal = head_q.illegal;

endmodule
